// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues a request-to-send and
// shifts one command byte out on device-generated clock falls, then collects the ack.
// Latency: clk pulled low 1 cycle after handshake; data follows each pin fall by 4 cycles.
// Backpressure: tx_ready is high only in IDLE; tx_valid is ignored while a frame is in flight.
//
// Ports:
//   clk, reset_n                          system clock, async active-low reset
//   ps2_clk_in, ps2_data_in               raw (asynchronous) pin levels
//   ps2_clk_drive_low, ps2_data_drive_low open-drain pull-down enables (registered)
//   tx_data, tx_valid, tx_ready           byte request handshake
//   busy                                  high whenever a frame is in progress
//   done, ack_err, timeout                completion pulse and its status flags
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 2500,
    parameter int TIMEOUT_CYCLES = 375000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_drive_low,
    output logic       ps2_data_drive_low,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       timeout
);

    localparam int IW = $clog2(INHIBIT_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        SEND,
        ACK,
        WAIT_IDLE
    } state_t;

    state_t          state;
    logic [7:0]      shift;
    logic            parity;
    logic [3:0]      bit_cnt;
    logic [IW-1:0]   inh_cnt;
    logic [TW-1:0]   tmo_cnt;

    logic clk_meta, clk_sync, clk_prev;
    logic data_meta, data_sync;
    logic fall;

    // Synchronisers reset to the released (high) level so that leaving reset
    // never manufactures a falling edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_meta  <= 1'b1;
            clk_sync  <= 1'b1;
            clk_prev  <= 1'b1;
            data_meta <= 1'b1;
            data_sync <= 1'b1;
            fall      <= 1'b0;
        end else begin
            clk_meta  <= ps2_clk_in;
            clk_sync  <= clk_meta;
            clk_prev  <= clk_sync;
            data_meta <= ps2_data_in;
            data_sync <= data_meta;
            fall      <= clk_prev & ~clk_sync;
        end
    end

    // Expiry is flagged one count early so that done appears on the very
    // cycle the count reaches TIMEOUT_CYCLES.
    logic tmo_hit;
    assign tmo_hit = (tmo_cnt >= TMO_LAST);

    assign tx_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state              <= IDLE;
            shift              <= 8'h00;
            parity             <= 1'b0;
            bit_cnt            <= 4'd0;
            inh_cnt            <= '0;
            tmo_cnt            <= '0;
            ps2_clk_drive_low  <= 1'b0;
            ps2_data_drive_low <= 1'b0;
            done               <= 1'b0;
            ack_err            <= 1'b0;
            timeout            <= 1'b0;
        end else begin
            done <= 1'b0;

            // Watchdog runs in every device-paced state; a fall (handled
            // below) takes priority and clears it.
            if ((state == SEND || state == ACK || state == WAIT_IDLE) && tmo_cnt != TMO_MAX)
                tmo_cnt <= tmo_cnt + 1'b1;

            unique case (state)
                IDLE: begin
                    ps2_clk_drive_low  <= 1'b0;
                    ps2_data_drive_low <= 1'b0;
                    if (tx_valid) begin
                        shift             <= tx_data;
                        parity            <= ~^tx_data;
                        ack_err           <= 1'b0;
                        timeout           <= 1'b0;
                        inh_cnt           <= '0;
                        ps2_clk_drive_low <= 1'b1;
                        state             <= INHIBIT;
                    end
                end

                INHIBIT: begin
                    if (inh_cnt == INH_LAST) begin
                        ps2_data_drive_low <= 1'b1;   // start bit
                        state              <= REQ;
                    end else begin
                        inh_cnt <= inh_cnt + 1'b1;
                    end
                end

                REQ: begin
                    ps2_clk_drive_low <= 1'b0;        // hand the clock to the device
                    bit_cnt           <= 4'd0;
                    tmo_cnt           <= '0;
                    state             <= SEND;
                end

                SEND: begin
                    if (fall) begin
                        tmo_cnt <= '0;
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt < 4'd8) begin
                            ps2_data_drive_low <= ~shift[0];
                            shift              <= {1'b0, shift[7:1]};
                        end else if (bit_cnt == 4'd8) begin
                            ps2_data_drive_low <= ~parity;
                        end else begin
                            ps2_data_drive_low <= 1'b0;   // stop bit: release
                            state              <= ACK;
                        end
                    end else if (tmo_hit) begin
                        ps2_clk_drive_low  <= 1'b0;
                        ps2_data_drive_low <= 1'b0;
                        tmo_cnt            <= TMO_MAX;
                        done               <= 1'b1;
                        timeout            <= 1'b1;
                        ack_err            <= 1'b0;
                        state              <= IDLE;
                    end
                end

                ACK: begin
                    if (fall) begin
                        tmo_cnt <= '0;
                        ack_err <= data_sync;         // device pulls data low to ack
                        state   <= WAIT_IDLE;
                    end else if (tmo_hit) begin
                        ps2_clk_drive_low  <= 1'b0;
                        ps2_data_drive_low <= 1'b0;
                        tmo_cnt            <= TMO_MAX;
                        done               <= 1'b1;
                        timeout            <= 1'b1;
                        ack_err            <= 1'b0;
                        state              <= IDLE;
                    end
                end

                WAIT_IDLE: begin
                    if (clk_sync && data_sync) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end else if (tmo_hit) begin
                        ps2_clk_drive_low  <= 1'b0;
                        ps2_data_drive_low <= 1'b0;
                        tmo_cnt            <= TMO_MAX;
                        done               <= 1'b1;
                        timeout            <= 1'b1;
                        ack_err            <= 1'b0;
                        state              <= IDLE;
                    end
                end

                default: begin
                    ps2_clk_drive_low  <= 1'b0;
                    ps2_data_drive_low <= 1'b0;
                    state              <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Testbench for ps2_host_tx: open-drain bus with a PS/2 device model (40-cycle clock)
// and a scoreboard of expected frames pushed at handshake, compared at done.
module tb_ps2_host_tx;

    localparam int INH = 8;
    localparam int TMO = 200;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;

    logic ps2_clk_drive_low, ps2_data_drive_low;
    logic tx_ready, busy, done, ack_err, timeout;
    logic ps2_clk_line, ps2_data_line;

    assign ps2_clk_line  = ~(ps2_clk_drive_low | dev_clk_low);
    assign ps2_data_line = ~(ps2_data_drive_low | dev_data_low);

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .ps2_clk_in         (ps2_clk_line),
        .ps2_data_in        (ps2_data_line),
        .ps2_clk_drive_low  (ps2_clk_drive_low),
        .ps2_data_drive_low (ps2_data_drive_low),
        .tx_data            (tx_data),
        .tx_valid           (tx_valid),
        .tx_ready           (tx_ready),
        .busy               (busy),
        .done               (done),
        .ack_err            (ack_err),
        .timeout            (timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       ack_err;
        logic       tmo;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    logic dev_bits [11];
    int   dev_nbits = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Odd parity bit: set when the byte has an even number of ones.
    function automatic logic odd_par(input logic [7:0] d);
        int ones = 0;
        for (int i = 0; i < 8; i++) if (d[i]) ones++;
        return (ones % 2 == 0);
    endfunction

    // Presents one byte; returns at the first negedge after the handshake edge.
    task automatic send_byte(input logic [7:0] d, input logic exp_ae, input logic exp_to);
        exp_t e;
        @(negedge clk);
        check("ready_before_hs", tx_ready, 1);
        tx_data  = d;
        tx_valid = 1'b1;
        e.data = d; e.par = odd_par(d); e.ack_err = exp_ae; e.tmo = exp_to;
        sb.push_back(e);
        @(negedge clk);
        tx_valid = 1'b0;
        check("busy_after_hs", busy, 1);
    endtask

    // Device: waits for request-to-send, clocks 11 pulses, samples each bit
    // when it releases the clock. abort_after>0 stops with clk held low.
    task automatic dev_xfer(input logic give_ack, input int abort_after);
        logic found;
        found = 1'b0;
        dev_nbits = 0;
        for (int i = 0; i < 500 && !found; i++) begin
            @(negedge clk);
            if (ps2_clk_line && !ps2_data_line) found = 1'b1;
        end
        check("dev_req_seen", found, 1);
        if (found) begin
            repeat (20) @(negedge clk);
            dev_bits[0] = ps2_data_line;
            dev_nbits = 1;
            for (int p = 1; p <= 11; p++) begin
                if (p == 11 && give_ack) begin
                    dev_data_low = 1'b1;
                    repeat (5) @(negedge clk);
                end
                dev_clk_low = 1'b1;
                repeat (20) @(negedge clk);
                if (p == abort_after) return;
                dev_clk_low = 1'b0;
                if (p <= 10) begin
                    dev_bits[p] = ps2_data_line;
                    dev_nbits++;
                end
                repeat (20) @(negedge clk);
            end
            dev_data_low = 1'b0;
        end
    endtask

    task automatic wait_done(input int bound, output logic seen, output logic ae, output logic to);
        seen = 1'b0; ae = 1'b0; to = 1'b0;
        for (int i = 0; i < bound && !seen; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                ae   = ack_err;
                to   = timeout;
                check("ready_with_done", tx_ready, 1);
                check("busy_with_done", busy, 0);
            end
        end
    endtask

    task automatic check_xfer(input logic got_ae, input logic got_to);
        exp_t e;
        logic [7:0] rx;
        check("sb_nonempty", (sb.size() != 0), 1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check("ack_err", got_ae, e.ack_err);
            check("timeout", got_to, e.tmo);
            if (!e.tmo) begin
                check("dev_nbits", dev_nbits, 11);
                check("start_bit", dev_bits[0], 0);
                for (int i = 0; i < 8; i++) rx[i] = dev_bits[i+1];
                check("data_byte", rx, e.data);
                check("parity_bit", dev_bits[9], e.par);
                check("stop_bit", dev_bits[10], 1);
            end
        end
    endtask

    task automatic run_xfer(input logic [7:0] d, input logic give_ack);
        logic seen, ae, to;
        send_byte(d, ~give_ack, 1'b0);
        fork
            dev_xfer(give_ack, 0);
            wait_done(3000, seen, ae, to);
        join
        check("done_seen", seen, 1);
        check_xfer(ae, to);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic seen, ae, to;
        int   done_m;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_ready", tx_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_clk_drv", ps2_clk_drive_low, 0);
        check("rst_data_drv", ps2_data_drive_low, 0);
        check("rst_done", done, 0);
        check("rst_flags", {ack_err, timeout}, 0);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);

        // Normal transfers with and without device ack
        run_xfer(8'hED, 1'b1);
        run_xfer(8'hF4, 1'b1);
        run_xfer(8'h00, 1'b0);
        repeat (10) @(negedge clk);
        check("ack_err_held", ack_err, 1);

        // Silent device: inhibit/request timing and timeout abort
        send_byte(8'h5A, 1'b0, 1'b1);
        done_m = -1;
        ae = 1'b0; to = 1'b0;
        for (int m = 1; m <= 400 && done_m < 0; m++) begin
            if (m > 1) @(negedge clk);
            if (m <= INH) begin
                check("inh_clk_drv", ps2_clk_drive_low, 1);
                check("inh_data_drv", ps2_data_drive_low, 0);
            end
            if (m == INH + 1) begin
                check("req_clk_drv", ps2_clk_drive_low, 1);
                check("req_data_drv", ps2_data_drive_low, 1);
            end
            if (m == INH + 2) begin
                check("send_clk_drv", ps2_clk_drive_low, 0);
                check("send_data_drv", ps2_data_drive_low, 1);
            end
            if (done) begin
                done_m = m;
                ae = ack_err;
                to = timeout;
            end
        end
        check("tmo_done_cycle", done_m, INH + 2 + TMO);
        check_xfer(ae, to);
        @(negedge clk);
        check("tmo_drives_released", {ps2_clk_drive_low, ps2_data_drive_low}, 0);
        repeat (5) @(negedge clk);

        // Request mid-frame is ignored
        send_byte(8'h3C, 1'b0, 1'b0);
        fork
            dev_xfer(1'b1, 0);
            wait_done(3000, seen, ae, to);
            begin
                repeat (100) @(negedge clk);
                tx_data  = 8'hAA;
                tx_valid = 1'b1;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    check("ready_low_midframe", tx_ready, 0);
                end
                tx_valid = 1'b0;
            end
        join
        check("done_seen_midframe", seen, 1);
        check_xfer(ae, to);
        repeat (30) @(negedge clk);
        check("no_extra_xfer", busy, 0);

        // Asynchronous reset mid-frame, then a clean transfer
        send_byte(8'h81, 1'b0, 1'b0);
        dev_xfer(1'b1, 5);
        check("pre_rst_data_drv", ps2_data_drive_low, 1);
        check("pre_rst_busy", busy, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_mid_clk_drv", ps2_clk_drive_low, 0);
        check("rst_mid_data_drv", ps2_data_drive_low, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_ready", tx_ready, 1);
        sb.delete();
        dev_clk_low  = 1'b0;
        dev_data_low = 1'b0;
        repeat (5) @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        run_xfer(8'hFF, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
